// File: rtl/pipe_controller.sv
// ---------------------------------------------------------------------------
// pipe_controller
//
// Control unit for the five-stage pipelined MIPS core. The op/funct pair of
// the instruction in Decode is decoded combinationally. The resulting control
// bundle is carried through the ID/EX, EX/MEM and MEM/WB registers, so the
// datapath can use the stage-tagged outputs directly. BEQ/BNE are resolved
// in Execute. Stall and flush requests turn the ID/EX load into a bubble.
// Illegal encodings are flagged. Instructions that retire from Writeback are
// counted.
//
// Parameters
//   ALUCTL_W    ALU control width (>= 3); the 3-bit codes are zero-extended
//   CNT_W       width of the retired-instruction counter
//   AUTO_FLUSH  1: a taken branch in E also bubbles the next ID/EX load
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous assert, synchronous release, active low
//   op_d, funct_d  opcode / funct of the instruction in D
//   stall_d        hold D, bubble into E
//   flush_e        bubble into E
//   zero_e         ALU zero flag of the instruction in E
//   jump_d         J decoded in D (combinational)
//   illegal_d      op/funct not in the decode table (combinational)
//   *_e            Execute-stage controls; pcsrc_e = branch taken
//   *_m            Memory-stage controls
//   *_w            Writeback-stage controls
//   illegal_seen   sticky: a valid illegal instruction has reached E
//   instret        count of valid instructions that left W (wraps)
// ---------------------------------------------------------------------------
module pipe_controller #(
  parameter int ALUCTL_W   = 3,
  parameter int CNT_W      = 32,
  parameter bit AUTO_FLUSH = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op_d,
  input  logic [5:0]          funct_d,
  input  logic                stall_d,
  input  logic                flush_e,
  input  logic                zero_e,
  output logic                jump_d,
  output logic                illegal_d,
  output logic                regwrite_e,
  output logic                memtoreg_e,
  output logic                memwrite_e,
  output logic                regdst_e,
  output logic [1:0]          alusrc_e,
  output logic [ALUCTL_W-1:0] alucontrol_e,
  output logic                pcsrc_e,
  output logic                regwrite_m,
  output logic                memtoreg_m,
  output logic                memwrite_m,
  output logic                regwrite_w,
  output logic                memtoreg_w,
  output logic                illegal_seen,
  output logic [CNT_W-1:0]    instret
);

  // -------------------------------------------------------------------------
  // Encodings
  // -------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
  localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_SIMM = 2'b01;
  localparam logic [1:0] SRC_ZIMM = 2'b10;

  // -------------------------------------------------------------------------
  // Stage bundles
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic                valid;
    logic                illegal;
    logic                branch;
    logic                bne;
    logic                regwrite;
    logic                memtoreg;
    logic                memwrite;
    logic                regdst;
    logic [1:0]          alusrc;
    logic [ALUCTL_W-1:0] alucontrol;
  } ctl_e_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } ctl_m_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
  } ctl_w_t;

  ctl_e_t            ctl_d;
  ctl_e_t            ctl_e_reg;
  ctl_m_t            ctl_m_reg;
  ctl_w_t            ctl_w_reg;
  logic              illegal_seen_reg;
  logic [CNT_W-1:0]  instret_reg;
  logic              bubble_e;

  // -------------------------------------------------------------------------
  // Decode (D, combinational)
  // Every field starts at 0 and only legal encodings set anything, so an
  // illegal or unknown encoding yields an all-zero bundle with illegal=1.
  // -------------------------------------------------------------------------
  always_comb begin
    ctl_d       = '0;
    ctl_d.valid = 1'b1;
    jump_d      = 1'b0;
    case (op_d)
      OP_RTYPE: begin
        case (funct_d)
          FN_NOP: ;
          FN_ADD: begin
            ctl_d.regwrite   = 1'b1;
            ctl_d.regdst     = 1'b1;
            ctl_d.alucontrol = ALU_ADD;
          end
          FN_SUB: begin
            ctl_d.regwrite   = 1'b1;
            ctl_d.regdst     = 1'b1;
            ctl_d.alucontrol = ALU_SUB;
          end
          FN_AND: begin
            ctl_d.regwrite   = 1'b1;
            ctl_d.regdst     = 1'b1;
            ctl_d.alucontrol = ALU_AND;
          end
          FN_OR: begin
            ctl_d.regwrite   = 1'b1;
            ctl_d.regdst     = 1'b1;
            ctl_d.alucontrol = ALU_OR;
          end
          FN_SLT: begin
            ctl_d.regwrite   = 1'b1;
            ctl_d.regdst     = 1'b1;
            ctl_d.alucontrol = ALU_SLT;
          end
          default: ctl_d.illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        ctl_d.regwrite   = 1'b1;
        ctl_d.alusrc     = SRC_SIMM;
        ctl_d.memtoreg   = 1'b1;
        ctl_d.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctl_d.alusrc     = SRC_SIMM;
        ctl_d.memwrite   = 1'b1;
        ctl_d.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        ctl_d.branch     = 1'b1;
        ctl_d.alucontrol = ALU_SUB;
      end
      OP_BNE: begin
        ctl_d.branch     = 1'b1;
        ctl_d.bne        = 1'b1;
        ctl_d.alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        ctl_d.regwrite   = 1'b1;
        ctl_d.alusrc     = SRC_SIMM;
        ctl_d.alucontrol = ALU_ADD;
      end
      OP_ANDI: begin
        ctl_d.regwrite   = 1'b1;
        ctl_d.alusrc     = SRC_ZIMM;
        ctl_d.alucontrol = ALU_AND;
      end
      OP_ORI: begin
        ctl_d.regwrite   = 1'b1;
        ctl_d.alusrc     = SRC_ZIMM;
        ctl_d.alucontrol = ALU_OR;
      end
      OP_SLTI: begin
        ctl_d.regwrite   = 1'b1;
        ctl_d.alusrc     = SRC_SIMM;
        ctl_d.alucontrol = ALU_SLT;
      end
      // J carries no E-stage controls; it still travels as a valid
      // instruction so it retires and is counted.
      OP_J: jump_d = 1'b1;
      default: ctl_d.illegal = 1'b1;
    endcase
  end

  assign illegal_d = ctl_d.illegal;

  // -------------------------------------------------------------------------
  // Branch resolution (E, combinational from zero_e)
  // Bubbles carry branch=0, so they can never redirect the PC.
  // -------------------------------------------------------------------------
  assign pcsrc_e = ctl_e_reg.branch & (zero_e ^ ctl_e_reg.bne);

  // stall_d, flush_e and a taken branch all collapse to one bubble.
  assign bubble_e = stall_d | flush_e | (AUTO_FLUSH & pcsrc_e);

  // -------------------------------------------------------------------------
  // Pipeline registers. EX/MEM and MEM/WB advance every cycle; an
  // instruction in E (including a taken branch) always moves on to M.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_e_reg <= '0;
      ctl_m_reg <= '0;
      ctl_w_reg <= '0;
    end else begin
      ctl_e_reg <= bubble_e ? '0 : ctl_d;

      ctl_m_reg.valid    <= ctl_e_reg.valid;
      ctl_m_reg.regwrite <= ctl_e_reg.regwrite;
      ctl_m_reg.memtoreg <= ctl_e_reg.memtoreg;
      ctl_m_reg.memwrite <= ctl_e_reg.memwrite;

      ctl_w_reg.valid    <= ctl_m_reg.valid;
      ctl_w_reg.regwrite <= ctl_m_reg.regwrite;
      ctl_w_reg.memtoreg <= ctl_m_reg.memtoreg;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky illegal flag. A flushed illegal instruction is replaced by a
  // bubble before it reaches E, so it never sets the flag. The flag is
  // visible in the same cycle the illegal instruction occupies E.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_seen_reg <= 1'b0;
    end else begin
      illegal_seen_reg <= illegal_seen;
    end
  end

  assign illegal_seen = illegal_seen_reg | (ctl_e_reg.valid & ctl_e_reg.illegal);

  // -------------------------------------------------------------------------
  // Retired-instruction counter, wraps modulo 2^CNT_W.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_reg <= '0;
    end else if (ctl_w_reg.valid) begin
      instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign instret = instret_reg;

  // -------------------------------------------------------------------------
  // Stage-tagged outputs
  // -------------------------------------------------------------------------
  assign regwrite_e   = ctl_e_reg.regwrite;
  assign memtoreg_e   = ctl_e_reg.memtoreg;
  assign memwrite_e   = ctl_e_reg.memwrite;
  assign regdst_e     = ctl_e_reg.regdst;
  assign alusrc_e     = ctl_e_reg.alusrc;
  assign alucontrol_e = ctl_e_reg.alucontrol;

  assign regwrite_m   = ctl_m_reg.regwrite;
  assign memtoreg_m   = ctl_m_reg.memtoreg;
  assign memwrite_m   = ctl_m_reg.memwrite;

  assign regwrite_w   = ctl_w_reg.regwrite;
  assign memtoreg_w   = ctl_w_reg.memtoreg;

endmodule
